// File: rtl/pdu_io_pkg.sv
// Shared address map and status-bit layout for the PDU I/O block.
package pdu_io_pkg;

   localparam logic [7:0] ADDR_LED      = 8'h00;
   localparam logic [7:0] ADDR_SW_STAT  = 8'h04;
   localparam logic [7:0] ADDR_SW_DATA  = 8'h08;
   localparam logic [7:0] ADDR_SEG_STAT = 8'h0C;
   localparam logic [7:0] ADDR_SEG_DATA = 8'h10;
   localparam logic [7:0] ADDR_BUTTONS  = 8'h14;
   localparam logic [7:0] ADDR_TIMER    = 8'h18;

   localparam int SW_STAT_VALID   = 0;
   localparam int SW_STAT_OVERRUN = 1;
   localparam int SEG_STAT_READY  = 0;

   localparam int PRESC_W = 16;

   typedef struct packed {
      logic [31:0] data;
      logic        overrun;
      logic        valid;
   } sw_mbox_t;

endpackage

// File: rtl/pdu_io_map_rise_edge.sv
// Rising-edge detector: registers the previous level, pulses for one clk on a 0->1 change.
module rise_edge (
   input  logic clk,
   input  logic rstn,
   input  logic in,
   output logic pulse
);

   logic prev;

   // prev resets low so a level held through reset yields one pulse after release
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) prev <= 1'b0;
      else       prev <= in;
   end

   assign pulse = in & ~prev;

endmodule

// File: rtl/pdu_io_map.sv
// CPU-facing register file for the PDU panel: LEDs, switch/segment mailboxes, buttons, timer.
module pdu_io_map
   import pdu_io_pkg::*;
#(
   parameter int CNT_DIV = 100,
   parameter int LED_W   = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [7:0]        io_addr,
   input  logic [31:0]       io_dout,
   input  logic              io_we,
   input  logic              io_rd,
   output logic [31:0]       io_din,
   input  logic              sw_we,
   input  logic [31:0]       switches_din,
   input  logic              seg_rd,
   output logic [31:0]       segment_dout,
   input  logic [31:0]       buttons_din,
   output logic [LED_W-1:0]  led_dout,
   output logic              sw_valid,
   output logic              seg_valid
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CNT_DIV - 1);

   sw_mbox_t           sw;
   logic               sw_rise, seg_rise;
   logic [31:0]        btn_s1, btn_s2;
   logic [31:0]        timer;
   logic [PRESC_W-1:0] presc;
   logic               tick;

   rise_edge u_sw_edge  (.clk(clk), .rstn(rstn), .in(sw_we),  .pulse(sw_rise));
   rise_edge u_seg_edge (.clk(clk), .rstn(rstn), .in(seg_rd), .pulse(seg_rise));

   wire wr_led   = io_we & (io_addr == ADDR_LED);
   wire wr_seg   = io_we & (io_addr == ADDR_SEG_DATA);
   wire wr_timer = io_we & (io_addr == ADDR_TIMER);
   wire rd_sw    = io_rd & (io_addr == ADDR_SW_DATA);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) led_dout <= '0;
      else if (wr_led) led_dout <= io_dout[LED_W-1:0];
   end

   // A new press in the same cycle as the data read wins and starts a fresh, non-overrun entry
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sw <= '0;
      end else if (sw_rise) begin
         sw.data    <= switches_din;
         sw.valid   <= 1'b1;
         sw.overrun <= sw.valid & ~rd_sw;
      end else if (rd_sw) begin
         sw.valid   <= 1'b0;
         sw.overrun <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         segment_dout <= '0;
         seg_valid    <= 1'b0;
      end else if (wr_seg) begin
         segment_dout <= io_dout;
         seg_valid    <= 1'b1;
      end else if (seg_rise) begin
         seg_valid    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
      end else begin
         btn_s1 <= buttons_din;
         btn_s2 <= btn_s1;
      end
   end

   assign tick = (presc == PRESC_MAX);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         presc <= '0;
         timer <= '0;
      end else if (wr_timer) begin
         presc <= '0;
         timer <= io_dout;
      end else begin
         presc <= tick ? '0 : presc + 1'b1;
         if (tick) timer <= timer + 32'd1;
      end
   end

   assign sw_valid = sw.valid;

   always_comb begin
      io_din = '0;
      case (io_addr)
         ADDR_LED:      io_din = 32'(led_dout);
         ADDR_SW_STAT: begin
            io_din[SW_STAT_VALID]   = sw.valid;
            io_din[SW_STAT_OVERRUN] = sw.overrun;
         end
         ADDR_SW_DATA:  io_din = sw.data;
         ADDR_SEG_STAT: io_din[SEG_STAT_READY] = ~seg_valid;
         ADDR_SEG_DATA: io_din = segment_dout;
         ADDR_BUTTONS:  io_din = btn_s2;
         ADDR_TIMER:    io_din = timer;
         default:       io_din = '0;
      endcase
   end

endmodule

// File: tb/tb_pdu_io_map.sv
// Directed bench for pdu_io_map: reads go through a scoreboard queue, pin checks are direct.
module tb_pdu_io_map;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [7:0]  io_addr = '0;
   logic [31:0] io_dout = '0;
   logic        io_we = 1'b0;
   logic        io_rd = 1'b0;
   logic [31:0] io_din;
   logic        sw_we = 1'b0;
   logic [31:0] switches_din = '0;
   logic        seg_rd = 1'b0;
   logic [31:0] segment_dout;
   logic [31:0] buttons_din = '0;
   logic [15:0] led_dout;
   logic        sw_valid;
   logic        seg_valid;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] exp;
   } rd_exp_t;

   rd_exp_t exp_q[$];
   int checks = 0;
   int errors = 0;

   pdu_io_map #(.CNT_DIV(4), .LED_W(16)) dut (
      .clk(clk), .rstn(rstn), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
      .io_rd(io_rd), .io_din(io_din), .sw_we(sw_we), .switches_din(switches_din),
      .seg_rd(seg_rd), .segment_dout(segment_dout), .buttons_din(buttons_din),
      .led_dout(led_dout), .sw_valid(sw_valid), .seg_valid(seg_valid)
   );

   always #5 clk = ~clk;

   // Monitor: every load cycle is sampled mid-cycle and compared against the queued expectation
   always @(negedge clk) begin
      if (io_rd) begin
         rd_exp_t e;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL read_unexpected addr=%h got=%h expected=<none queued>", io_addr, io_din);
         end else begin
            e = exp_q.pop_front();
            if (io_din !== e.exp || io_addr !== e.addr) begin
               errors++;
               $display("FAIL read_%h got=%h (addr %h) expected=%h", e.addr, io_din, io_addr, e.exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic rd(input logic [7:0] a, input logic [31:0] exp);
      rd_exp_t e;
      e.addr = a;
      e.exp  = exp;
      exp_q.push_back(e);
      io_addr = a;
      io_rd   = 1'b1;
      tick();
      io_rd   = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      io_addr = a;
      io_dout = d;
      io_we   = 1'b1;
      tick();
      io_we   = 1'b0;
   endtask

   task automatic press(input logic [31:0] v);
      switches_din = v;
      sw_we = 1'b1;
      tick();
      sw_we = 1'b0;
      tick();
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_led", 32'(led_dout), 32'h0);
      chk("rst_seg_dout", segment_dout, 32'h0);
      chk("rst_flags", {30'h0, sw_valid, seg_valid}, 32'h0);
      rstn = 1'b1;
      tick();
      rd(8'h00, 32'h0);
      rd(8'h04, 32'h0);
      rd(8'h0C, 32'h1);
      rd(8'h10, 32'h0);

      // Held switch-ready level counts as one press
      switches_din = 32'h1234;
      sw_we = 1'b1;
      repeat (50) tick();
      chk("sw_valid_held", 32'(sw_valid), 32'h1);
      rd(8'h04, 32'h1);
      rd(8'h08, 32'h1234);
      rd(8'h04, 32'h0);
      sw_we = 1'b0;
      tick();

      press(32'hA);
      press(32'hB);
      rd(8'h04, 32'h3);
      rd(8'h08, 32'hB);
      rd(8'h04, 32'h0);

      wr(8'h10, 32'hDEADBEEF);
      chk("seg_dout_store", segment_dout, 32'hDEADBEEF);
      rd(8'h0C, 32'h0);
      seg_rd = 1'b1;
      tick();
      seg_rd = 1'b0;
      tick();
      rd(8'h0C, 32'h1);
      // Store and consume edge together: the store must win
      io_addr = 8'h10; io_dout = 32'hCAFEF00D; io_we = 1'b1; seg_rd = 1'b1;
      tick();
      io_we = 1'b0; seg_rd = 1'b0;
      rd(8'h0C, 32'h0);
      chk("seg_dout_race", segment_dout, 32'hCAFEF00D);
      chk("seg_valid_race", 32'(seg_valid), 32'h1);

      // Timer wraps from all-ones after one prescaler period of 4 clk
      wr(8'h18, 32'hFFFFFFFF);
      rd(8'h18, 32'hFFFFFFFF);
      repeat (3) tick();
      rd(8'h18, 32'h0);
      repeat (3) tick();
      rd(8'h18, 32'h1);

      wr(8'h00, 32'h0001FFFF);
      chk("led_trunc", 32'(led_dout), 32'h0000FFFF);
      rd(8'h00, 32'h0000FFFF);
      wr(8'h40, 32'h55);
      rd(8'h40, 32'h0);
      rd(8'h00, 32'h0000FFFF);
      rd(8'h10, 32'hCAFEF00D);

      buttons_din = 32'hC3;
      tick();
      rd(8'h14, 32'h0);
      rd(8'h14, 32'hC3);

      // Reset mid-handshake with the switch level held high through release
      switches_din = 32'h77;
      sw_we = 1'b1;
      tick();
      wr(8'h10, 32'h99);
      chk("pre_rst_flags", {30'h0, sw_valid, seg_valid}, 32'h3);
      #2 rstn = 1'b0;
      #1;
      chk("rst_async_flags", {30'h0, sw_valid, seg_valid}, 32'h0);
      chk("rst_async_led", 32'(led_dout), 32'h0);
      chk("rst_async_seg", segment_dout, 32'h0);
      tick();
      rstn = 1'b1;
      tick();
      chk("sw_valid_post_rst", 32'(sw_valid), 32'h1);
      rd(8'h04, 32'h1);

      // Press landing on the data-read cycle: fresh entry, no overrun
      sw_we = 1'b0;
      tick();
      switches_din = 32'h88;
      sw_we = 1'b1;
      rd(8'h08, 32'h77);
      sw_we = 1'b0;
      rd(8'h04, 32'h1);
      rd(8'h08, 32'h88);
      rd(8'h04, 32'h0);

      repeat (2) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got=%0d expected=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pdu_io_map.md
Name: pdu_io_map

Overview:
- Memory-mapped I/O block between the CPU IO bus and the PDU front panel.
- Decodes CPU loads and stores to LED, switch-input, segment-output, button and timer registers.
- Switch input and segment output each use a one-entry valid/ready mailbox, so CPU polling programs can handshake with the PDU buttons.
- Direct downstream consumer of the PDU panel signals: DataMove value, debounced centre/left buttons, button levels.

Parameters:
- CNT_DIV, 100, system clocks per timer tick (100 = 1 us at 100 MHz); legal range 1..65535.
- LED_W, 16, width of LED output register.

Ports:
- clk  in  1  system clock 100 MHz
- rstn  in  1  asynchronous active-low reset
- io_addr  in  8  CPU IO byte address, word aligned
- io_dout  in  32  CPU store data
- io_we  in  1  CPU store strobe, one clk per store
- io_rd  in  1  CPU load strobe, one clk per load
- io_din  out  32  CPU load data
- sw_we  in  1  PDU "switch data ready" level (debounced button)
- switches_din  in  32  PDU switch value
- seg_rd  in  1  PDU "segment data consumed" level
- segment_dout  out  32  value for 7-segment display
- buttons_din  in  32  raw button/switch levels
- led_dout  out  LED_W  LED register
- sw_valid  out  1  switch mailbox full
- seg_valid  out  1  segment mailbox full

Behaviour:
- Clock and reset: clk, rstn async active-low.
- Reset values: led_dout=0, segment_dout=0, sw_valid=0, seg_valid=0, overrun=0, sw_data=0, timer=0, prescaler=0, sync flops=0.
- Address map (io_addr); R/W is from the CPU side:
  - 0x00 LED, R/W.
  - 0x04 SW_STAT, R: bit0=sw_valid, bit1=overrun.
  - 0x08 SW_DATA, R.
  - 0x0C SEG_STAT, R: bit0=~seg_valid, meaning ready.
  - 0x10 SEG_DATA, R/W.
  - 0x14 BUTTONS, R.
  - 0x18 TIMER, R/W.
  - Unused bits read 0.
  - Other addresses: read 0, writes ignored.
- Read path: io_din is combinational from io_addr. It is valid in the same cycle, independent of io_rd. Side effects happen only on clk edges where io_rd=1.
- Writes take effect on the clk edge where io_we=1. LED takes io_dout[LED_W-1:0].
- sw_we and seg_rd pass through rise-edge detectors (registered previous level). Each press acts exactly once, one cycle after the rising edge.
- Switch mailbox:
  - A sw_we rise latches switches_din into sw_data and sets sw_valid.
  - If sw_valid was already 1, overrun is set and the new data overwrites the old.
  - An io_rd of SW_DATA clears sw_valid and overrun.
  - A sw_we rise in the same cycle as the SW_DATA read wins: sw_valid=1, overrun=0.
- Segment mailbox:
  - An io_we to SEG_DATA loads segment_dout and sets seg_valid.
  - A seg_rd rise clears seg_valid.
  - Both in the same cycle: write wins, seg_valid=1.
  - Writing while seg_valid=1 overwrites; no error flag.
- BUTTONS: buttons_din passes through a 2-flop synchroniser. Read latency is 2 clk.
- Timer:
  - The prescaler counts 0..CNT_DIV-1. Each wrap increments the 32-bit timer, which wraps at 0xFFFFFFFF to 0.
  - An io_we to TIMER loads io_dout and zeroes the prescaler. A write in a tick cycle wins over the increment.
- io_we and io_rd asserted together: both honoured.
- Reset mid-operation clears all state immediately. Edge detectors reset to 0, so a button held through reset release produces one rise on the first sampled high after release.

Decomposition:
- Package pdu_io_pkg holds:
  - address localparams: ADDR_LED, ADDR_SW_STAT, ADDR_SW_DATA, ADDR_SEG_STAT, ADDR_SEG_DATA, ADDR_BUTTONS, ADDR_TIMER;
  - status bit-index constants.
- Sub-module rise_edge (clk, rstn, in, pulse), instantiated for sw_we and seg_rd.

Test Plan:
- Reset, then read 0x00/0x04/0x0C/0x10 -> 0, 0, 1, 0; led_dout=0, segment_dout=0.
- switches_din=0x1234, hold sw_we high 50 clk -> sw_valid=1 after one rise only. Read 0x04 -> 1, read 0x08 -> 0x1234, then 0x04 -> 0.
- Two sw_we presses (0xA, then 0xB) without a read -> 0x04 reads 3, 0x08 reads 0xB, then 0x04 reads 0.
- Store 0xDEADBEEF to 0x10 -> segment_dout=0xDEADBEEF, 0x0C reads 0. seg_rd pulse -> 0x0C reads 1. Store and seg_rd rise in the same cycle -> 0x0C reads 0.
- CNT_DIV=4: store 0xFFFFFFFF to 0x18 -> after 4 clk reads 0, after 8 clk reads 1.
- Store 0x1_FFFF to 0x00 -> led_dout=0xFFFF. Store to 0x40 -> no state change, read 0x40 -> 0. Assert rstn=0 mid-handshake -> all flags 0 within the same cycle.
